// File: rtl/sspim_pkg.sv
// sspim_pkg -- shared definitions for the single-SPI master sequencer.
//
// Contents:
//   SSPIM_DIV_W     default width of the SCK half-period divider
//   SSPIM_OP_*      operation type encodings (2'b11 behaves as write-read)
//   sspim_state_e   sequencer states
//   sspim_reads     true when an op type captures receive data
//   sspim_tx_byte   selects transmit byte idx (0 = wr_data[31:24]),
//                   or 8'h00 for read-only ops

package sspim_pkg;

    localparam int SSPIM_DIV_W = 8;

    localparam logic [1:0] SSPIM_OP_WR   = 2'b00;
    localparam logic [1:0] SSPIM_OP_RD   = 2'b01;
    localparam logic [1:0] SSPIM_OP_WRRD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } sspim_state_e;

    function automatic logic sspim_reads(input logic [1:0] op);
        return op != SSPIM_OP_WR;
    endfunction

    function automatic logic [7:0] sspim_tx_byte(input logic [31:0] data,
                                                 input logic [1:0]  idx,
                                                 input logic [1:0]  op);
        logic [31:0] aligned;
        aligned = data << {idx, 3'b000};
        return (op == SSPIM_OP_RD) ? 8'h00 : aligned[31:24];
    endfunction

endpackage

// File: rtl/sspim_clkgen.sv
// sspim_clkgen -- SCK half-period divider for the SPI master sequencer.
//
// Counts 0..hm1 while 'run' is high; the last count of each half period
// raises phase_end. At a phase end with 'tgl' high the SCK phase flips.
// 'park' forces the phase back to the idle level for the next cycle.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   run            sequencer is in an active state this cycle
//   tgl            flip the SCK phase at the end of this half period
//   park           next cycle is idle; return SCK to its idle level
//   idle_lvl       SCK idle level to use for the next cycle
//   hm1            half period minus one (latched divider)
//   phase_end      last cycle of the current half period
//   phase_hi       current half period is the non-idle SCK level
//   div_nxt        divider count for the next cycle
//   hi_nxt         phase_hi for the next cycle
//   sck_int        registered serial clock

module sspim_clkgen
    import sspim_pkg::*;
#(
    parameter int DIV_W = SSPIM_DIV_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             tgl,
    input  logic             park,
    input  logic             idle_lvl,
    input  logic [DIV_W-1:0] hm1,
    output logic             phase_end,
    output logic             phase_hi,
    output logic [DIV_W-1:0] div_nxt,
    output logic             hi_nxt,
    output logic             sck_int
);

    logic [DIV_W-1:0] div_q;

    // Next values are exported so the sequencer can decode its registered
    // outputs for the coming cycle from the same counter state.
    always_comb begin
        phase_end = run && (div_q == hm1);
        div_nxt   = (run && !phase_end) ? div_q + 1'b1 : '0;
        hi_nxt    = phase_hi;
        if (park) begin
            hi_nxt = 1'b0;
        end else if (phase_end && tgl) begin
            hi_nxt = ~phase_hi;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            phase_hi <= 1'b0;
            sck_int  <= 1'b0;
        end else begin
            div_q    <= div_nxt;
            phase_hi <= hi_nxt;
            sck_int  <= idle_lvl ^ hi_nxt;
        end
    end

endmodule

// File: rtl/sspim_ctl.sv
// sspim_ctl -- sequencer for the single-SPI master shift interface.
//
// Runs one 1..4 byte transaction per accepted request (write, read or
// write-read). SCK half period is cfg_sck_div+1 clocks. All outputs come
// straight from flops: the next-cycle state is decoded and registered.
//
// Build option:
//   SSPIM_CPOL_EN  adds cfg_cpol; SCK idles at the latched cfg_cpol level
//                  and both phases are inverted. While idle, sck_int
//                  follows cfg_cpol from the first clock after reset.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   op_req            start request (level), accepted only when idle
//   cfg_op_type       00 write, 01 read, 10/11 write-read
//   cfg_xfr_len       byte count minus one
//   cfg_sck_div       SCK half period minus one
//   cfg_cpol          (SSPIM_CPOL_EN only) SCK idle level
//   wr_data           transmit bytes, first byte in [31:24]
//   rd_data           receive bytes shifted in from the right
//   busy / op_done    op in progress / one-cycle completion pulse
//   sck_int, cs_int_n serial clock and active-low chip select
//   load_byte         load byte_out into the shift register
//   byte_out          byte to transmit
//   sck_active        qualifies shift/sample
//   shift / sample    drive next bit / capture incoming bit
//   byte_in           received byte from the shift interface

module sspim_ctl
    import sspim_pkg::*;
#(
    parameter int DIV_W = SSPIM_DIV_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_req,
    input  logic [1:0]       cfg_op_type,
    input  logic [1:0]       cfg_xfr_len,
    input  logic [DIV_W-1:0] cfg_sck_div,
`ifdef SSPIM_CPOL_EN
    input  logic             cfg_cpol,
`endif
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             op_done,
    output logic             sck_int,
    output logic             cs_int_n,
    output logic             load_byte,
    output logic [7:0]       byte_out,
    output logic             sck_active,
    output logic             shift,
    output logic             sample,
    input  logic [7:0]       byte_in
);

    sspim_state_e     state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       len_q, len_d;
    logic [DIV_W-1:0] hm1_q, hm1_d;
    logic [31:0]      wr_q, wr_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic             cap_q, cap_d;

    logic             phase_end, phase_hi, hi_d;
    logic [DIV_W-1:0] div_d;
    logic             idle_d;

    logic             load_d, shift_d, sample_d, done_d, active_d;
    logic [7:0]       byte_out_d;

`ifdef SSPIM_CPOL_EN
    logic cpol_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpol_q <= 1'b0;
        end else if (state_q == IDLE && op_req) begin
            cpol_q <= cfg_cpol;
        end
    end

    assign idle_d = (state_q == IDLE) ? cfg_cpol : cpol_q;
`else
    assign idle_d = 1'b0;
`endif

    sspim_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (state_q != IDLE),
        .tgl       (state_q != HOLD),
        .park      (state_d == IDLE),
        .idle_lvl  (idle_d),
        .hm1       (hm1_q),
        .phase_end (phase_end),
        .phase_hi  (phase_hi),
        .div_nxt   (div_d),
        .hi_nxt    (hi_d),
        .sck_int   (sck_int)
    );

    // HOLD is the low half of the final bit, so XFER leaves straight after
    // the last sample. bit/byte counters advance at the end of a low half.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        hm1_d   = hm1_q;
        wr_d    = wr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        cap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_req) begin
                    state_d = SETUP;
                    op_d    = cfg_op_type;
                    len_d   = cfg_xfr_len;
                    hm1_d   = cfg_sck_div;
                    wr_d    = wr_data;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (phase_end) begin
                    if (phase_hi) begin
                        cap_d = (bit_q == 3'd7) && sspim_reads(op_q);
                        if (bit_q == 3'd7 && byte_q == len_q) begin
                            state_d = HOLD;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 2'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-cycle strobes. The next byte is loaded together with the shift
    // that closes bit 6 of the current byte, so the shifter never starves.
    always_comb begin
        active_d = (state_d != IDLE);
        load_d   = ((state_d == SETUP) && (div_d == '0)) ||
                   ((state_d == XFER) && !hi_d && (div_d == hm1_d) &&
                    (bit_d == 3'd6) && (byte_d < len_d));
        shift_d  = ((state_d == SETUP) || ((state_d == XFER) && !hi_d)) &&
                   (div_d == hm1_d);
        sample_d = (state_d == XFER) && hi_d && (div_d == hm1_d);
        done_d   = (state_q == HOLD) && phase_end;
        byte_out_d = byte_out;
        if (load_d) begin
            byte_out_d = sspim_tx_byte(wr_d,
                                       (state_d == SETUP) ? 2'd0 : byte_d + 2'd1,
                                       op_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            len_q      <= '0;
            hm1_q      <= '0;
            wr_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            cap_q      <= 1'b0;
            cs_int_n   <= 1'b1;
            busy       <= 1'b0;
            op_done    <= 1'b0;
            load_byte  <= 1'b0;
            byte_out   <= '0;
            sck_active <= 1'b0;
            shift      <= 1'b0;
            sample     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            hm1_q      <= hm1_d;
            wr_q       <= wr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            cap_q      <= cap_d;
            cs_int_n   <= !active_d;
            busy       <= active_d;
            op_done    <= done_d;
            load_byte  <= load_d;
            byte_out   <= byte_out_d;
            sck_active <= active_d;
            shift      <= shift_d;
            sample     <= sample_d;
        end
    end

    // The interface assembles byte_in during the cycle after the 8th
    // sample; it is taken at the end of that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (cap_q) begin
            rd_data <= {rd_data[23:0], byte_in};
        end
    end

endmodule

// File: tb/tb_sspim_ctl.sv
// tb_sspim_ctl -- self-checking bench for sspim_ctl.
//
// Each issued op pushes its expected behaviour into a scoreboard queue.
// A monitor records every cycle of chip-select-low activity and, on each
// op_done, pops the oldest expectation and compares timing, bytes and
// rd_data. A small slave model returns bytes on byte_in.

module tb_sspim_ctl;

`ifdef SSPIM_CPOL_EN
    localparam bit CPOL = 1'b1;
`else
    localparam bit CPOL = 1'b0;
`endif

    typedef struct {
        int          div;
        int          len;
        logic [1:0]  op;
        logic [31:0] wr;
        logic [31:0] rdExp;
    } txn_t;

    logic        clk;
    logic        reset_n;
    logic        op_req;
    logic [1:0]  cfg_op_type;
    logic [1:0]  cfg_xfr_len;
    logic [7:0]  cfg_sck_div;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy, op_done, sck_int, cs_int_n, load_byte;
    logic [7:0]  byte_out;
    logic        sck_active, shift, sample;
    logic [7:0]  byte_in;
`ifdef SSPIM_CPOL_EN
    logic        cfg_cpol;
    assign cfg_cpol = CPOL;
`endif

    sspim_ctl #(.DIV_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_req      (op_req),
        .cfg_op_type (cfg_op_type),
        .cfg_xfr_len (cfg_xfr_len),
        .cfg_sck_div (cfg_sck_div),
`ifdef SSPIM_CPOL_EN
        .cfg_cpol    (cfg_cpol),
`endif
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .op_done     (op_done),
        .sck_int     (sck_int),
        .cs_int_n    (cs_int_n),
        .load_byte   (load_byte),
        .byte_out    (byte_out),
        .sck_active  (sck_active),
        .shift       (shift),
        .sample      (sample),
        .byte_in     (byte_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    txn_t        sb[$];
    logic [31:0] rxq[$];
    logic [31:0] rdModel = 32'h0;

    // monitor state
    int          t = 0;
    int          shQ[$];
    int          saQ[$];
    int          ldQ[$];
    logic [7:0]  lbQ[$];
    bit          sckQ[$];
    int          ctlErr = 0;
    int          idleErr = 0;
    int          postReset = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] txByte(input txn_t e, input int n);
        if (e.op == 2'b01) return 8'h00;
        return 8'(e.wr >> (8 * (3 - n)));
    endfunction

    task automatic clearMonitor();
        t = 0;
        shQ.delete(); saQ.delete(); ldQ.delete(); lbQ.delete(); sckQ.delete();
        ctlErr = 0;
    endtask

    // Expected timeline, counted in cycles from the first chip-select-low
    // cycle (t=1): one setup half period, then two half periods per bit,
    // the low half of the final bit being the hold time.
    task automatic compareOp(input txn_t e);
        int H, nbits, T, mis, tt;
        bit hi;
        int expSh[$];
        int expSa[$];
        int expLd[$];
        logic [7:0] expLb[$];
        H = e.div + 1;
        nbits = 8 * (e.len + 1);
        T = H * (16 * (e.len + 1) + 1);
        checkOutput("cs_low_cycles", t, T);
        checkOutput("cs_high_on_done", cs_int_n, 1);
        checkOutput("busy_low_on_done", busy, 0);
        expSh.push_back(H);
        for (int k = 0; k < nbits - 1; k++) expSh.push_back(H * (2 * k + 3));
        for (int k = 0; k < nbits; k++) expSa.push_back(H * (2 * k + 2));
        expLd.push_back(1);
        expLb.push_back(txByte(e, 0));
        for (int n = 0; n < e.len; n++) begin
            expLd.push_back(H * (2 * (8 * n + 6) + 3));
            expLb.push_back(txByte(e, n + 1));
        end
        checkOutput("shift_count", shQ.size(), expSh.size());
        mis = 0;
        for (int i = 0; i < shQ.size() && i < expSh.size(); i++) if (shQ[i] != expSh[i]) mis++;
        checkOutput("shift_time_errors", mis, 0);
        checkOutput("sample_count", saQ.size(), expSa.size());
        mis = 0;
        for (int i = 0; i < saQ.size() && i < expSa.size(); i++) if (saQ[i] != expSa[i]) mis++;
        checkOutput("sample_time_errors", mis, 0);
        checkOutput("load_count", ldQ.size(), expLd.size());
        mis = 0;
        for (int i = 0; i < ldQ.size() && i < expLd.size(); i++)
            if (ldQ[i] != expLd[i] || lbQ[i] != expLb[i]) mis++;
        checkOutput("load_time_byte_errors", mis, 0);
        mis = 0;
        for (int i = 0; i < sckQ.size(); i++) begin
            tt = i + 1;
            hi = (tt > H) && (tt <= H * (2 * nbits + 1)) && ((((tt - H - 1) / H) % 2) == 0);
            if (sckQ[i] != (CPOL ^ hi)) mis++;
        end
        checkOutput("sck_wave_errors", mis, 0);
        checkOutput("active_busy_errors", ctlErr, 0);
        checkOutput("rd_data", rd_data, e.rdExp);
    endtask

    // Monitor: record activity while chip select is low, compare on op_done.
    always @(negedge clk) begin
        txn_t e;
        if (!reset_n) begin
            clearMonitor();
            postReset = 0;
        end else begin
            if (postReset < 3) postReset++;
            if (!cs_int_n) begin
                t++;
                if (shift) shQ.push_back(t);
                if (sample) saQ.push_back(t);
                if (load_byte) begin
                    ldQ.push_back(t);
                    lbQ.push_back(byte_out);
                end
                if (!sck_active || !busy) ctlErr++;
                sckQ.push_back(sck_int);
            end else begin
                if (shift || sample || load_byte || sck_active || busy) idleErr++;
                if (postReset >= 2 && sck_int != CPOL) idleErr++;
            end
            if (op_done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_op_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    compareOp(e);
                end
                clearMonitor();
            end
        end
    end

    // Slave model: after each byte's 8th sample present that byte on byte_in.
    logic [31:0] curRx = 32'h0;
    int          nSamp = 0;
    logic        csPrev = 1'b1;
    always @(negedge clk) begin
        if (!reset_n) begin
            nSamp   = 0;
            byte_in = 8'h00;
            csPrev  = 1'b1;
        end else begin
            if (!cs_int_n && csPrev) begin
                curRx = (rxq.size() > 0) ? rxq.pop_front() : 32'h0;
                nSamp = 0;
            end
            if (!cs_int_n && sample) begin
                nSamp++;
                if (nSamp % 8 == 0) byte_in = 8'(curRx >> (8 * (3 - (nSamp / 8 - 1))));
            end
            csPrev = cs_int_n;
        end
    end

    // Drive the config for one op and record its expected outcome.
    task automatic pushOp(input logic [1:0] op, input logic [1:0] len, input int div,
                          input logic [31:0] wr, input logic [31:0] rx);
        txn_t e;
        int lenI;
        lenI = int'(len);
        cfg_op_type = op;
        cfg_xfr_len = len;
        cfg_sck_div = 8'(div);
        wr_data     = wr;
        if (op != 2'b00)
            for (int n = 0; n <= lenI; n++) rdModel = (rdModel << 8) | {24'h0, 8'(rx >> (8 * (3 - n)))};
        e.div = div; e.len = lenI; e.op = op; e.wr = wr; e.rdExp = rdModel;
        sb.push_back(e);
        rxq.push_back(rx);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] len, input int div,
                                 input logic [31:0] wr, input logic [31:0] rx, input bit hold);
        int n;
        @(negedge clk);
        pushOp(op, len, div, wr, rx);
        op_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 4);
        checkOutput("accepted", busy, 1);
        if (!hold) op_req = 1'b0;
        // config changes after accept must not disturb the running op
        cfg_op_type = 2'($urandom_range(0, 3));
        cfg_xfr_len = 2'($urandom_range(0, 3));
        cfg_sck_div = 8'($urandom_range(0, 255));
        wr_data     = $urandom;
    endtask

    task automatic waitDone();
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20000) begin
            @(negedge clk);
            n++;
            if (op_done) seen = 1;
        end
        checkOutput("op_done_within_budget", seen, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cs_int_n"}, cs_int_n, 1);
        checkOutput({tag, "_sck_int"}, sck_int, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_op_done"}, op_done, 0);
        checkOutput({tag, "_load_byte"}, load_byte, 0);
        checkOutput({tag, "_shift"}, shift, 0);
        checkOutput({tag, "_sample"}, sample, 0);
        checkOutput({tag, "_sck_active"}, sck_active, 0);
        checkOutput({tag, "_byte_out"}, byte_out, 0);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        op_req = 1'b0;
        cfg_op_type = 2'b00;
        cfg_xfr_len = 2'b00;
        cfg_sck_div = 8'h00;
        wr_data = 32'h0;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] write 1 byte, div 0");
        applyStimulus(2'b00, 2'd0, 0, 32'hA500_0000, 32'h0, 0);
        waitDone();

        $display("[TB] write-read 4 bytes looped back, div 0");
        applyStimulus(2'b10, 2'd3, 0, 32'h1234_5678, 32'h1234_5678, 0);
        waitDone();
        checkOutput("loopback_rd_data", rd_data, 32'h1234_5678);

        $display("[TB] read 2 bytes, div 3");
        applyStimulus(2'b01, 2'd1, 3, 32'hFFFF_FFFF, 32'hC33C_0000, 0);
        waitDone();
        checkOutput("read_rd_low16", rd_data[15:0], 16'hC33C);

        $display("[TB] back-to-back ops with op_req held");
        applyStimulus(2'b00, 2'd0, 1, 32'h5A00_0000, 32'h0, 1);
        waitDone();
        pushOp(2'b01, 2'd1, 0, 32'h0, 32'h9966_0000);
        @(negedge clk);
        checkOutput("b2b_second_cs_low", cs_int_n, 0);
        checkOutput("b2b_second_busy", busy, 1);
        repeat (3) begin
            @(negedge clk) op_req = 1'b0;
            @(negedge clk) op_req = 1'b1;
        end
        @(negedge clk) op_req = 1'b0;
        waitDone();

        $display("[TB] reset during byte 2 bit 4");
        applyStimulus(2'b10, 2'd3, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
        repeat (41) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetValues("abort");
        sb.delete();
        rxq.delete();
        rdModel = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(2'b10, 2'd1, 2, 32'hA1B2_0000, 32'h7E81_0000, 0);
        waitDone();

        $display("[TB] randomized ops");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 5)), $urandom, $urandom, 0);
            waitDone();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checkOutput("idle_quiet_errors", idleErr, 0);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
